// File: rtl/scl_stall_pkg.sv
// Shared types for the SCL stall controller: FSM state encoding and its width.
package scl_stall_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/scl_stall_arb.sv
// Masked fixed-priority arbiter: the lowest-index requester that is still eligible wins.
module scl_stall_arb
    import scl_stall_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [NUM_CH-1:0] elig_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic              valid_o
);

    logic [NUM_CH-1:0] cand;

    // Two's-complement trick isolates the lowest set bit of the candidate vector.
    always_comb begin
        cand    = req_i & elig_i;
        grant_o = cand & (~cand + NUM_CH'(1));
        valid_o = |cand;
    end

endmodule

// File: rtl/scl_stall_ctrl.sv
// Multi-requester SCL stall controller: arbitrates stall requests and holds o_scl_stall
// for the latched cycle count, then pulses the owner's done bit for one cycle.
//
// Handshake: a requester raises i_stall_req[i] and holds it until it sees o_stall_done[i];
// the request must be sampled low at least once before the same channel can win again.
module scl_stall_ctrl
    import scl_stall_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    i_stall_clk,
    input  logic                    i_stall_rst,
    input  logic [NUM_CH-1:0]       i_stall_req,
    input  logic [NUM_CH*CNT_W-1:0] i_stall_cycles,
    input  logic                    i_stall_abort,
    output logic                    o_scl_stall,
    output logic                    o_stall_busy,
    output logic [NUM_CH-1:0]       o_stall_grant,
    output logic [NUM_CH-1:0]       o_stall_done,
    output logic                    o_stall_aborted,
    output logic [CNT_W-1:0]        o_stall_remaining,
    output logic [ST_W-1:0]         o_dbg_state
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] elig_q, elig_d;
    logic              aborted_q, aborted_d;
    logic              stall_q, stall_d;
    logic              busy_q, busy_d;

    logic [NUM_CH-1:0] arb_grant;
    logic              arb_valid;
    logic [CNT_W-1:0]  win_cnt;

    scl_stall_arb #(.NUM_CH(NUM_CH)) u_arb (
        .req_i   (i_stall_req),
        .elig_i  (elig_q),
        .grant_o (arb_grant),
        .valid_o (arb_valid)
    );

    always_comb begin
        win_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_grant[i]) begin
                win_cnt = win_cnt | i_stall_cycles[i*CNT_W +: CNT_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        grant_d   = grant_q;
        done_d    = '0;
        aborted_d = 1'b0;
        stall_d   = stall_q;
        busy_d    = busy_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                stall_d = 1'b0;
                busy_d  = 1'b0;
                rem_d   = '0;
                if (arb_valid) begin
                    grant_d = arb_grant;
                    busy_d  = 1'b1;
                    // A zero count skips STALL entirely so the bus is never held.
                    if (win_cnt != '0) begin
                        state_d = ST_STALL;
                        stall_d = 1'b1;
                        rem_d   = win_cnt;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = arb_grant;
                    end
                end
            end
            ST_STALL: begin
                if (i_stall_abort || rem_q == CNT_W'(1)) begin
                    state_d   = ST_DONE;
                    stall_d   = 1'b0;
                    rem_d     = '0;
                    done_d    = grant_q;
                    aborted_d = i_stall_abort;
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                stall_d = 1'b0;
                busy_d  = 1'b0;
                rem_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                stall_d = 1'b0;
                busy_d  = 1'b0;
                rem_d   = '0;
            end
        endcase

        // Re-arm only after a sampled low request; the done pulse disarms its owner.
        elig_d = (elig_q | ~i_stall_req) & ~done_d;
    end

    always_ff @(posedge i_stall_clk) begin
        if (i_stall_rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            elig_q    <= '1;
            aborted_q <= 1'b0;
            stall_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            elig_q    <= elig_d;
            aborted_q <= aborted_d;
            stall_q   <= stall_d;
            busy_q    <= busy_d;
        end
    end

    assign o_scl_stall       = stall_q;
    assign o_stall_busy      = busy_q;
    assign o_stall_grant     = grant_q;
    assign o_stall_done      = done_q;
    assign o_stall_aborted   = aborted_q;
    assign o_stall_remaining = rem_q;
    assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_scl_stall_ctrl.sv
// Self-checking bench for scl_stall_ctrl: directed scenarios plus a short random phase,
// with completed stalls scored against an expected queue of {done, aborted, length}.
module tb_scl_stall_ctrl;
    import scl_stall_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic                    clk;
    logic                    rst;
    logic [NUM_CH-1:0]       req;
    logic [CNT_W-1:0]        cyc [NUM_CH];
    logic [NUM_CH*CNT_W-1:0] cycles_packed;
    logic                    abort;
    logic                    o_scl_stall;
    logic                    o_stall_busy;
    logic [NUM_CH-1:0]       o_stall_grant;
    logic [NUM_CH-1:0]       o_stall_done;
    logic                    o_stall_aborted;
    logic [CNT_W-1:0]        o_stall_remaining;
    logic [ST_W-1:0]         o_dbg_state;

    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int run_len  = 0;

    assign cycles_packed = {cyc[3], cyc[2], cyc[1], cyc[0]};

    scl_stall_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .i_stall_clk       (clk),
        .i_stall_rst       (rst),
        .i_stall_req       (req),
        .i_stall_cycles    (cycles_packed),
        .i_stall_abort     (abort),
        .o_scl_stall       (o_scl_stall),
        .o_stall_busy      (o_stall_busy),
        .o_stall_grant     (o_stall_grant),
        .o_stall_done      (o_stall_done),
        .o_stall_aborted   (o_stall_aborted),
        .o_stall_remaining (o_stall_remaining),
        .o_dbg_state       (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [15:0] exp_item(input logic [3:0] d, input logic a, input int len);
        return {d, a, 3'b000, 8'(len)};
    endfunction

    // Scoreboard: every done pulse must match the oldest expected stall.
    always @(negedge clk) begin
        logic [15:0] got;
        logic [15:0] e;
        if (rst) begin
            run_len = 0;
        end else begin
            if (o_scl_stall) run_len++;
            if (o_stall_done != '0) begin
                got = {o_stall_done, o_stall_aborted, 3'b000, 8'(run_len)};
                check_val("done_scl_low", o_scl_stall, 0);
                check_val("done_busy", o_stall_busy, 1);
                check_val("done_rem", o_stall_remaining, 0);
                if (exp_q.size() == 0) begin
                    check_val("sb_unexpected_done", got, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("sb_item", got, e);
                    check_val("sb_grant", o_stall_grant, e[15:12]);
                end
                run_len = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input string tag, input int budget);
        bit seen = 0;
        int k = 0;
        while (!seen && k < budget) begin
            @(negedge clk);
            k++;
            seen = (o_stall_done != '0);
        end
        check_val(tag, seen, 1);
    endtask

    task automatic wait_stall_cycles(input string tag, input int n, input int budget);
        int cnt = 0;
        int k = 0;
        while (cnt < n && k < budget) begin
            @(negedge clk);
            k++;
            if (o_scl_stall) cnt++;
        end
        check_val(tag, cnt, n);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_scl"}, o_scl_stall, 0);
        check_val({tag, "_busy"}, o_stall_busy, 0);
        check_val({tag, "_grant"}, o_stall_grant, 0);
        check_val({tag, "_done"}, o_stall_done, 0);
        check_val({tag, "_aborted"}, o_stall_aborted, 0);
        check_val({tag, "_rem"}, o_stall_remaining, 0);
        check_val({tag, "_state"}, o_dbg_state, ST_IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int busy_seen;
        int ch;
        int n;

        rst   = 1'b1;
        req   = '0;
        abort = 1'b0;
        for (int i = 0; i < NUM_CH; i++) cyc[i] = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: single 5-cycle stall on ch0
        cyc[0] = 8'd5;
        req    = 4'b0001;
        exp_q.push_back(exp_item(4'b0001, 1'b0, 5));
        @(negedge clk);
        check_val("t1_scl", o_scl_stall, 1);
        check_val("t1_rem", o_stall_remaining, 5);
        check_val("t1_grant", o_stall_grant, 4'b0001);
        check_val("t1_busy", o_stall_busy, 1);
        check_val("t1_state", o_dbg_state, ST_STALL);
        wait_done("t1_done_seen", 20);
        req = '0;
        @(negedge clk);
        check_all_zero("t1_idle");

        // 2: zero-count request on ch2 never raises SCL stall
        cyc[2] = 8'd0;
        req    = 4'b0100;
        exp_q.push_back(exp_item(4'b0100, 1'b0, 0));
        @(negedge clk);
        check_val("t2_done", o_stall_done, 4'b0100);
        check_val("t2_busy", o_stall_busy, 1);
        check_val("t2_scl", o_scl_stall, 0);
        check_val("t2_state", o_dbg_state, ST_DONE);
        req = '0;
        @(negedge clk);
        check_val("t2_busy_low", o_stall_busy, 0);
        check_val("t2_done_low", o_stall_done, 0);

        // 3: simultaneous ch1 and ch3, lowest index first
        cyc[1] = 8'd3;
        cyc[3] = 8'd4;
        req    = 4'b1010;
        exp_q.push_back(exp_item(4'b0010, 1'b0, 3));
        exp_q.push_back(exp_item(4'b1000, 1'b0, 4));
        wait_done("t3_ch1_done_seen", 20);
        @(negedge clk);
        check_val("t3_gap_scl", o_scl_stall, 0);
        check_val("t3_gap_busy", o_stall_busy, 0);
        wait_done("t3_ch3_done_seen", 20);
        req = '0;
        repeat (2) @(negedge clk);

        // 4: held request does not restart; drop and re-raise does
        cyc[0] = 8'd2;
        req    = 4'b0001;
        exp_q.push_back(exp_item(4'b0001, 1'b0, 2));
        wait_done("t4_first_done_seen", 20);
        busy_seen = 0;
        repeat (10) begin
            @(negedge clk);
            busy_seen |= int'(o_stall_busy);
        end
        check_val("t4_no_restart", busy_seen, 0);
        req = '0;
        @(negedge clk);
        req = 4'b0001;
        exp_q.push_back(exp_item(4'b0001, 1'b0, 2));
        wait_done("t4_second_done_seen", 20);
        req = '0;
        repeat (2) @(negedge clk);

        // 5: abort after 10 stall cycles of a 200-cycle request
        cyc[0] = 8'd200;
        req    = 4'b0001;
        exp_q.push_back(exp_item(4'b0001, 1'b1, 10));
        wait_stall_cycles("t5_ten_cycles", 10, 50);
        check_val("t5_rem", o_stall_remaining, 191);
        abort = 1'b1;
        wait_done("t5_done_seen", 5);
        check_val("t5_aborted", o_stall_aborted, 1);
        abort = 1'b0;
        req   = '0;
        @(negedge clk);
        check_val("t5_aborted_clear", o_stall_aborted, 0);
        repeat (2) @(negedge clk);

        // 6: reset mid-stall, held request re-granted afterwards
        cyc[0] = 8'd100;
        req    = 4'b0001;
        wait_stall_cycles("t6_51_cycles", 51, 80);
        check_val("t6_rem", o_stall_remaining, 50);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("t6_reset");
        rst    = 1'b0;
        cyc[0] = 8'd3;
        exp_q.push_back(exp_item(4'b0001, 1'b0, 3));
        @(negedge clk);
        check_val("t6_regrant_scl", o_scl_stall, 1);
        check_val("t6_regrant_grant", o_stall_grant, 4'b0001);
        wait_done("t6_done_seen", 10);
        req = '0;
        repeat (2) @(negedge clk);

        // random single-channel transactions
        for (int it = 0; it < 8; it++) begin
            ch      = $urandom_range(0, NUM_CH - 1);
            n       = $urandom_range(0, 12);
            cyc[ch] = 8'(n);
            req     = 4'(1 << ch);
            exp_q.push_back(exp_item(4'(1 << ch), 1'b0, n));
            wait_done("rnd_done_seen", 30);
            req = '0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check_val("sb_drain", exp_q.size(), 0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
